ddr3_axi_bist: RTL and testbench

//  Built-in self-test sequencer for the DDR3 AXI4 slave port (axi_ddr3_lite) at 100 MHz. On start: writes NUM_BURSTS INCR bursts with an address-derived pattern, reads them back, compares every beat, counts errors.

---
 rtl/ddr3_axi_bist.sv | 240 ++++++++++++++++++++++++
 tb/tb_ddr3_axi_bist.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_axi_bist.sv
// -----------------------------------------------------------------------------
// ddr3_axi_bist
// Built-in self-test sequencer for the DDR3 AXI4 slave port. A start pulse
// launches one pass. The pass writes NUM_BURSTS INCR bursts of BURST_LEN beats,
// contiguous from byte address 0. Each beat carries an address-derived pattern.
// The pass then reads every burst back and checks each beat. Every bad write
// response and every bad read beat adds one to a saturating error counter.
// Only one burst is ever outstanding. Every output is registered.
//
// Ports
//   clock, reset        controller clock; synchronous active-high reset
//   start_i             pulse to begin a pass (honoured only when idle/done)
//   busy_o, done_o      pass in progress / pass finished (held until restart)
//   err_count_o         saturating error count of the last/current pass
//   axi_aw*             write-address channel (addr, len, valid/ready)
//   axi_w*              write-data channel (data, last, valid/ready)
//   axi_b*              write-response channel (resp, valid/ready)
//   axi_ar*             read-address channel (addr, len, valid/ready)
//   axi_r*              read-data channel (data, resp, last, valid/ready)
// -----------------------------------------------------------------------------
module ddr3_axi_bist #(
    parameter int ADDRS      = 27,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int NUM_BURSTS = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           err_count_o,
    output logic                  axi_awvalid_o,
    input  logic                  axi_awready_i,
    output logic [ADDRS-1:0]      axi_awaddr_o,
    output logic [7:0]            axi_awlen_o,
    output logic                  axi_wvalid_o,
    input  logic                  axi_wready_i,
    output logic                  axi_wlast_o,
    output logic [DATA_WIDTH-1:0] axi_wdata_o,
    input  logic                  axi_bvalid_i,
    output logic                  axi_bready_o,
    input  logic [1:0]            axi_bresp_i,
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    output logic [ADDRS-1:0]      axi_araddr_o,
    output logic [7:0]            axi_arlen_o,
    input  logic                  axi_rvalid_i,
    output logic                  axi_rready_o,
    input  logic                  axi_rlast_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic [DATA_WIDTH-1:0] axi_rdata_i
);

    localparam int BEAT_W  = 9;
    localparam int BURST_W = $clog2(NUM_BURSTS + 1);

    localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0]    LAST_BURST  = BURST_W'(NUM_BURSTS - 1);
    localparam logic [ADDRS-1:0]      BEAT_BYTES  = ADDRS'(4);
    localparam logic [ADDRS-1:0]      BURST_BYTES = ADDRS'(BURST_LEN * 4);
    localparam logic [7:0]            AXLEN       = 8'(BURST_LEN - 1);
    localparam logic [DATA_WIDTH-1:0] PATTERN_KEY = DATA_WIDTH'(32'h5A5A_5A5A);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WDATA = 3'd2,
        ST_WRESP = 3'd3,
        ST_RADDR = 3'd4,
        ST_RDATA = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Test word for a byte address: the zero-extended address XOR a fixed key.
    function automatic logic [DATA_WIDTH-1:0] pattern_word(input logic [ADDRS-1:0] addr);
        pattern_word = DATA_WIDTH'(addr) ^ PATTERN_KEY;
    endfunction

    // Error counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            sat_inc = value;
        end else begin
            sat_inc = value + 16'd1;
        end
    endfunction

    state_t               state_r;
    logic [BURST_W-1:0]   burst_r;
    logic [BEAT_W-1:0]    beat_r;
    logic [ADDRS-1:0]     base_r;
    logic [ADDRS-1:0]     beat_addr_r;

    logic [ADDRS-1:0]     next_beat_addr_s;
    logic [ADDRS-1:0]     next_base_s;
    logic [BEAT_W-1:0]    next_beat_s;
    logic                 beat_is_last_s;
    logic                 burst_is_last_s;
    logic                 read_bad_s;

    assign next_beat_addr_s = beat_addr_r + BEAT_BYTES;
    assign next_base_s      = base_r + BURST_BYTES;
    assign next_beat_s      = beat_r + 9'd1;
    assign beat_is_last_s   = (beat_r == LAST_BEAT);
    assign burst_is_last_s  = (burst_r == LAST_BURST);
    // A bad beat is counted once, even when the data, response and rlast are all wrong.
    assign read_bad_s       = (axi_rdata_i != pattern_word(beat_addr_r)) ||
                              (axi_rresp_i != 2'b00) ||
                              (axi_rlast_i != beat_is_last_s);

    // Pass sequencer: state, counters, error tally and every registered AXI output
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            burst_r       <= '0;
            beat_r        <= '0;
            base_r        <= '0;
            beat_addr_r   <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_count_o   <= 16'd0;
            axi_awvalid_o <= 1'b0;
            axi_awaddr_o  <= '0;
            axi_awlen_o   <= 8'd0;
            axi_wvalid_o  <= 1'b0;
            axi_wlast_o   <= 1'b0;
            axi_wdata_o   <= '0;
            axi_bready_o  <= 1'b0;
            axi_arvalid_o <= 1'b0;
            axi_araddr_o  <= '0;
            axi_arlen_o   <= 8'd0;
            axi_rready_o  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_r       <= ST_WADDR;
                        busy_o        <= 1'b1;
                        done_o        <= 1'b0;
                        err_count_o   <= 16'd0;
                        burst_r       <= '0;
                        base_r        <= '0;
                        axi_awvalid_o <= 1'b1;
                        axi_awaddr_o  <= '0;
                        axi_awlen_o   <= AXLEN;
                        axi_arlen_o   <= AXLEN;
                    end
                end
                ST_WADDR: begin
                    if (axi_awready_i) begin
                        // W is launched only after its AW has been accepted.
                        state_r       <= ST_WDATA;
                        axi_awvalid_o <= 1'b0;
                        axi_wvalid_o  <= 1'b1;
                        axi_wdata_o   <= pattern_word(base_r);
                        axi_wlast_o   <= (LAST_BEAT == 9'd0);
                        beat_r        <= '0;
                        beat_addr_r   <= base_r;
                    end
                end
                ST_WDATA: begin
                    if (axi_wready_i) begin
                        if (beat_is_last_s) begin
                            state_r      <= ST_WRESP;
                            axi_wvalid_o <= 1'b0;
                            axi_wlast_o  <= 1'b0;
                            axi_bready_o <= 1'b1;
                        end else begin
                            beat_r       <= next_beat_s;
                            beat_addr_r  <= next_beat_addr_s;
                            axi_wdata_o  <= pattern_word(next_beat_addr_s);
                            axi_wlast_o  <= (next_beat_s == LAST_BEAT);
                        end
                    end
                end
                ST_WRESP: begin
                    if (axi_bvalid_i) begin
                        axi_bready_o <= 1'b0;
                        if (axi_bresp_i != 2'b00) begin
                            err_count_o <= sat_inc(err_count_o);
                        end
                        if (burst_is_last_s) begin
                            // Writes complete: rewind to burst 0 for the read-back.
                            state_r       <= ST_RADDR;
                            burst_r       <= '0;
                            base_r        <= '0;
                            axi_arvalid_o <= 1'b1;
                            axi_araddr_o  <= '0;
                        end else begin
                            state_r       <= ST_WADDR;
                            burst_r       <= burst_r + 1'b1;
                            base_r        <= next_base_s;
                            axi_awvalid_o <= 1'b1;
                            axi_awaddr_o  <= next_base_s;
                        end
                    end
                end
                ST_RADDR: begin
                    if (axi_arready_i) begin
                        state_r       <= ST_RDATA;
                        axi_arvalid_o <= 1'b0;
                        axi_rready_o  <= 1'b1;
                        beat_r        <= '0;
                        beat_addr_r   <= base_r;
                    end
                end
                ST_RDATA: begin
                    if (axi_rvalid_i) begin
                        if (read_bad_s) begin
                            err_count_o <= sat_inc(err_count_o);
                        end
                        // The burst ends on the beat count alone, whatever rlast says.
                        if (beat_is_last_s) begin
                            axi_rready_o <= 1'b0;
                            if (burst_is_last_s) begin
                                state_r <= ST_DONE;
                                busy_o  <= 1'b0;
                                done_o  <= 1'b1;
                            end else begin
                                state_r       <= ST_RADDR;
                                burst_r       <= burst_r + 1'b1;
                                base_r        <= next_base_s;
                                axi_arvalid_o <= 1'b1;
                                axi_araddr_o  <= next_base_s;
                            end
                        end else begin
                            beat_r      <= next_beat_s;
                            beat_addr_r <= next_beat_addr_s;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_axi_bist.sv
// -----------------------------------------------------------------------------
// tb_ddr3_axi_bist
// Bench for ddr3_axi_bist (BURST_LEN=16, NUM_BURSTS=4).
// A behavioural AXI slave holds a word memory. It inserts random stalls and can
// inject faults. Expected addresses, data and error counts are derived from the
// address arithmetic of the pattern, not from the sequencer's structure.
// -----------------------------------------------------------------------------
module tb_ddr3_axi_bist;

    localparam int ADDRS = 27;
    localparam int BL    = 16;
    localparam int NB    = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_i;
    logic        busy_o, done_o;
    logic [15:0] err_count_o;
    logic        axi_awvalid_o, axi_awready_i;
    logic [ADDRS-1:0] axi_awaddr_o, axi_araddr_o;
    logic [7:0]  axi_awlen_o, axi_arlen_o;
    logic        axi_wvalid_o, axi_wready_i, axi_wlast_o;
    logic [31:0] axi_wdata_o, axi_rdata_i;
    logic        axi_bvalid_i, axi_bready_o;
    logic [1:0]  axi_bresp_i, axi_rresp_i;
    logic        axi_arvalid_o, axi_arready_i;
    logic        axi_rvalid_i, axi_rready_o, axi_rlast_i;

    ddr3_axi_bist #(.ADDRS(ADDRS), .DATA_WIDTH(32), .BURST_LEN(BL), .NUM_BURSTS(NB)) dut (
        .clock(clock), .reset(reset), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .err_count_o(err_count_o),
        .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
        .axi_awaddr_o(axi_awaddr_o), .axi_awlen_o(axi_awlen_o),
        .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
        .axi_wlast_o(axi_wlast_o), .axi_wdata_o(axi_wdata_o),
        .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o), .axi_bresp_i(axi_bresp_i),
        .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
        .axi_araddr_o(axi_araddr_o), .axi_arlen_o(axi_arlen_o),
        .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o),
        .axi_rlast_i(axi_rlast_i), .axi_rresp_i(axi_rresp_i), .axi_rdata_i(axi_rdata_i)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard check: counts every comparison and reports mismatches
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference pattern: zero-extended 27-bit byte address XOR 0x5A5A5A5A
    function automatic logic [31:0] ref_word(input int addr);
        logic [31:0] a;
        a = addr;
        a[31:27] = 5'd0;
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // Slave / scoreboard state
    logic [31:0] mem [0:255];
    int  stall_pct = 0;
    int  mode = 0;          // 0 clean, 1 bad read @0x44 + one BRESP=2, 2 early rlast in burst 1
    int  aw_n, w_n, b_n, ar_n, r_n;
    int  wbase, wbeat, rbase, rbeat, rburst;
    bit  w_open, r_active;
    int  b_owed;
    logic [31:0] first_wdata;
    bit  aw_pend, w_pend, ar_pend;
    logic [ADDRS-1:0] aw_pend_addr, ar_pend_addr;
    logic [31:0] w_pend_data;

    function automatic bit stall();
        return ($urandom_range(99) < stall_pct);
    endfunction

    // Slave state and protocol checks, sampled at the active edge
    always @(posedge clock) begin
        if (reset) begin
            w_open = 0; r_active = 0; b_owed = 0;
            aw_pend = 0; w_pend = 0; ar_pend = 0;
        end else begin
            if (aw_pend) begin
                check_eq("aw_hold_valid", axi_awvalid_o, 1);
                check_eq("aw_hold_addr", axi_awaddr_o, aw_pend_addr);
            end
            if (w_pend) begin
                check_eq("w_hold_valid", axi_wvalid_o, 1);
                check_eq("w_hold_data", axi_wdata_o, w_pend_data);
            end
            if (ar_pend) begin
                check_eq("ar_hold_valid", axi_arvalid_o, 1);
                check_eq("ar_hold_addr", axi_araddr_o, ar_pend_addr);
            end
            if (axi_wvalid_o) check_eq("w_after_aw", w_open, 1);
            aw_pend = axi_awvalid_o && !axi_awready_i;
            aw_pend_addr = axi_awaddr_o;
            w_pend = axi_wvalid_o && !axi_wready_i;
            w_pend_data = axi_wdata_o;
            ar_pend = axi_arvalid_o && !axi_arready_i;
            ar_pend_addr = axi_araddr_o;

            if (axi_awvalid_o && axi_awready_i) begin
                check_eq("aw_addr", axi_awaddr_o, aw_n * BL * 4);
                check_eq("aw_len", axi_awlen_o, BL - 1);
                wbase = aw_n * BL * 4; wbeat = 0; w_open = 1; aw_n++;
            end
            if (axi_wvalid_o && axi_wready_i) begin
                check_eq("w_data", axi_wdata_o, ref_word(wbase + 4 * wbeat));
                check_eq("w_last", axi_wlast_o, (wbeat == BL - 1));
                if (w_n == 0) first_wdata = axi_wdata_o;
                mem[((wbase + 4 * wbeat) >> 2) & 255] = axi_wdata_o;
                w_n++; wbeat++;
                if (wbeat == BL) begin w_open = 0; b_owed++; end
            end
            if (axi_bvalid_i && axi_bready_o) begin b_owed--; b_n++; end
            if (axi_arvalid_o && axi_arready_i) begin
                check_eq("ar_addr", axi_araddr_o, ar_n * BL * 4);
                check_eq("ar_len", axi_arlen_o, BL - 1);
                rbase = ar_n * BL * 4; rburst = ar_n; rbeat = 0; r_active = 1; ar_n++;
            end
            if (axi_rvalid_i && axi_rready_o) begin
                r_n++; rbeat++;
                if (rbeat == BL) r_active = 0;
            end
        end
    end

    // Slave drives its ready/valid/data away from the active edge
    always @(negedge clock) begin
        if (reset) begin
            axi_awready_i = 0; axi_wready_i = 0; axi_arready_i = 0;
            axi_bvalid_i = 0; axi_bresp_i = 0;
            axi_rvalid_i = 0; axi_rlast_i = 0; axi_rresp_i = 0; axi_rdata_i = 0;
        end else begin
            int a;
            axi_awready_i = !stall();
            axi_wready_i  = !stall();
            axi_arready_i = !stall();
            axi_bvalid_i  = (b_owed > 0) && (axi_bvalid_i || !stall());
            axi_bresp_i   = (mode == 1 && b_n == 0) ? 2'd2 : 2'd0;
            axi_rvalid_i  = r_active && (axi_rvalid_i || !stall());
            a = rbase + 4 * rbeat;
            axi_rdata_i   = mem[(a >> 2) & 255];
            if (mode == 1 && a == 32'h44) axi_rdata_i[0] = ~axi_rdata_i[0];
            axi_rlast_i   = (mode == 2 && rburst == 1) ? (rbeat == 14) : (rbeat == BL - 1);
            axi_rresp_i   = 2'd0;
        end
    end

    // One complete pass; optional stray start while busy
    task automatic run_pass(input int stall_in, input int mode_in, input int exp_err, input bit poke);
        int cyc;
        @(negedge clock);
        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
        first_wdata = 32'hDEAD_BEEF;
        stall_pct = stall_in; mode = mode_in;
        start_i = 1;
        @(negedge clock);
        start_i = 0;
        check_eq("start_busy", busy_o, 1);
        check_eq("start_awvalid", axi_awvalid_o, 1);
        check_eq("start_done_low", done_o, 0);
        check_eq("start_err_clr", err_count_o, 0);
        if (poke) begin
            repeat (20) @(negedge clock);
            start_i = 1;
            @(negedge clock);
            start_i = 0;
        end
        cyc = 0;
        while (!done_o && cyc < 5000) begin
            @(negedge clock);
            cyc++;
        end
        check_eq("done_reached", done_o, 1);
        check_eq("done_busy", busy_o, 0);
        check_eq("err_count", err_count_o, exp_err);
        check_eq("aw_count", aw_n, NB);
        check_eq("w_count", w_n, NB * BL);
        check_eq("b_count", b_n, NB);
        check_eq("ar_count", ar_n, NB);
        check_eq("r_count", r_n, NB * BL);
        check_eq("beat0_data", first_wdata, 32'h5A5A_5A5A);
        repeat (5) @(negedge clock);
        check_eq("done_held", done_o, 1);
        check_eq("err_held", err_count_o, exp_err);
        check_eq("idle_awvalid", axi_awvalid_o, 0);
    endtask

    initial begin
        int cyc;
        reset = 1; start_i = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_err", err_count_o, 0);
        check_eq("rst_valids", {axi_awvalid_o, axi_wvalid_o, axi_arvalid_o, axi_bready_o, axi_rready_o}, 0);
        check_eq("rst_awaddr", axi_awaddr_o, 0);
        check_eq("rst_lens", {axi_awlen_o, axi_arlen_o}, 0);
        check_eq("rst_wdata", axi_wdata_o, 0);
        reset = 0;

        run_pass(0, 0, 0, 0);
        run_pass(30, 0, 0, 1);
        run_pass(0, 1, 2, 0);
        run_pass(25, 2, 2, 0);

        // Reset in the middle of the write-data phase
        @(negedge clock);
        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
        stall_pct = 30; mode = 0;
        start_i = 1;
        @(negedge clock);
        start_i = 0;
        cyc = 0;
        while (!(axi_wvalid_o && w_n >= 20) && cyc < 2000) begin
            @(negedge clock);
            cyc++;
        end
        check_eq("mid_wdata_reached", axi_wvalid_o, 1);
        reset = 1;
        @(negedge clock);
        check_eq("mid_rst_valids", {axi_awvalid_o, axi_wvalid_o, axi_arvalid_o}, 0);
        check_eq("mid_rst_busy", busy_o, 0);
        check_eq("mid_rst_done", done_o, 0);
        reset = 0;
        run_pass(30, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
